// File: rtl/voice_allocator.sv
// Purpose: polyphony scheduler binding pressed keys of an 88-key vector to a small pool of voices.
// Latency: one key examined per clock; an action on key k is visible the cycle after idx==k; sweep = NUM_KEYS+2 cycles.
// Backpressure: none; iSCAN_EN low lets the current sweep finish and then parks in IDLE. Optional: VOICE_STEAL_EN.
module voice_allocator #(
    parameter int NUM_KEYS   = 88,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 7,
    parameter int AGE_W      = 3
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iSCAN_EN,
    input  logic                        iCLR,
    input  logic [NUM_KEYS-1:0]         iKEYS,
    output logic [NUM_VOICES*KEY_W-1:0] oVOICE_KEY,
    output logic [NUM_VOICES-1:0]       oVOICE_GATE,
    output logic [NUM_VOICES-1:0]       oVOICE_TRIG,
    output logic                        oDROP,
    output logic                        oSWEEP_DONE,
    output logic                        oANY_GATE
);

    localparam int                 VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [KEY_W-1:0]   LAST_IDX = KEY_W'(NUM_KEYS - 1);
    localparam logic [AGE_W-1:0]   AGE_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [NUM_KEYS-1:0]   r_snap;
    logic [KEY_W-1:0]      r_idx;
    logic [KEY_W-1:0]      r_key  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;
    logic [NUM_VOICES-1:0] r_trig;
    logic                  r_drop;
    logic                  r_done;

    logic                  w_key_dn;
    logic                  w_bound;
    logic [VIDX_W-1:0]     w_bound_v;
    logic                  w_free;
    logic [VIDX_W-1:0]     w_free_v;
    logic                  w_alloc;
    logic [VIDX_W-1:0]     w_alloc_v;
    logic                  w_drop;
`ifdef VOICE_STEAL_EN
    logic [VIDX_W-1:0]     w_old_v;
    logic [AGE_W-1:0]      w_old_age;
`endif

    // Decode the scanned key against the voice table: bound voice, lowest free voice, allocation target.
    always_comb begin
        w_key_dn  = r_snap[r_idx];
        w_bound   = 1'b0;
        w_bound_v = '0;
        w_free    = 1'b0;
        w_free_v  = '0;
        w_alloc   = 1'b0;
        w_alloc_v = '0;
        w_drop    = 1'b0;
        // a key is only ever bound to one gated voice, so at most one match fires
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_gate[v] && (r_key[v] == r_idx)) begin
                w_bound   = 1'b1;
                w_bound_v = VIDX_W'(v);
            end
        end
        // walk downwards so the lowest-index free voice is the one that sticks
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_gate[v]) begin
                w_free   = 1'b1;
                w_free_v = VIDX_W'(v);
            end
        end
`ifdef VOICE_STEAL_EN
        // oldest voice wins; strict compare keeps the lowest index on ties
        w_old_v   = '0;
        w_old_age = r_age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (r_age[v] > w_old_age) begin
                w_old_age = r_age[v];
                w_old_v   = VIDX_W'(v);
            end
        end
        if ((r_state == ST_SCAN) && w_key_dn && !w_bound) begin
            w_alloc   = 1'b1;
            w_alloc_v = w_free ? w_free_v : w_old_v;
        end
`else
        if ((r_state == ST_SCAN) && w_key_dn && !w_bound) begin
            w_alloc   = w_free;
            w_alloc_v = w_free_v;
            w_drop    = !w_free;
        end
`endif
    end

    // Sweep FSM plus voice table; pulses default low and are raised for exactly one cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_snap  <= '0;
            r_idx   <= '0;
            r_gate  <= '0;
            r_trig  <= '0;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_key[v] <= '0;
                r_age[v] <= '0;
            end
        end else begin
            r_trig <= '0;
            r_drop <= 1'b0;
            r_done <= 1'b0;
            if (iCLR) begin
                // release everything and restart the sweep from a fresh snapshot; key indices kept for tails
                r_gate  <= '0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    r_age[v] <= '0;
                end
                r_state <= iSCAN_EN ? ST_SNAP : ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (iSCAN_EN) begin
                            r_state <= ST_SNAP;
                        end
                    end
                    ST_SNAP: begin
                        r_snap  <= iKEYS;
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                    end
                    ST_SCAN: begin
                        if (w_alloc) begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (VIDX_W'(v) == w_alloc_v) begin
                                    r_key[v]  <= r_idx;
                                    r_gate[v] <= 1'b1;
                                    r_trig[v] <= 1'b1;
                                    r_age[v]  <= '0;
                                end else if (r_gate[v] && (r_age[v] != AGE_MAX)) begin
                                    r_age[v]  <= r_age[v] + AGE_W'(1);
                                end
                            end
                        end else if (!w_key_dn && w_bound) begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (VIDX_W'(v) == w_bound_v) begin
                                    r_gate[v] <= 1'b0;
                                    r_age[v]  <= '0;
                                end
                            end
                        end
                        r_drop <= w_drop;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + KEY_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= iSCAN_EN ? ST_SNAP : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Flatten the per-voice key indices onto the packed output bus.
    always_comb begin
        oVOICE_KEY = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            oVOICE_KEY[v*KEY_W +: KEY_W] = r_key[v];
        end
    end

    assign oVOICE_GATE = r_gate;
    assign oVOICE_TRIG = r_trig;
    assign oDROP       = r_drop;
    assign oSWEEP_DONE = r_done;
    assign oANY_GATE   = |r_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: reset, sweep timing, allocation, release, overflow, clear, scan stop, reset mid-sweep.
// Expected values are hand-derived from the sweep schedule (snapshot two edges after DONE, key k acted on three edges plus k later).
// Overflow expectations follow the VOICE_STEAL_EN setting the bench is compiled with.
module tb_voice_allocator;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSCAN_EN;
    logic        iCLR;
    logic [87:0] iKEYS;
    logic [27:0] oVOICE_KEY;
    logic [3:0]  oVOICE_GATE;
    logic [3:0]  oVOICE_TRIG;
    logic        oDROP;
    logic        oSWEEP_DONE;
    logic        oANY_GATE;

    int n_chk  = 0;
    int n_fail = 0;

    int trig_cnt [4];
    int drop_cnt;
    int done_cnt;
    int first_trig;
    int sweep_len;

    voice_allocator dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iSCAN_EN    (iSCAN_EN),
        .iCLR        (iCLR),
        .iKEYS       (iKEYS),
        .oVOICE_KEY  (oVOICE_KEY),
        .oVOICE_GATE (oVOICE_GATE),
        .oVOICE_TRIG (oVOICE_TRIG),
        .oDROP       (oDROP),
        .oSWEEP_DONE (oSWEEP_DONE),
        .oANY_GATE   (oANY_GATE)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] pack(input int k0, input int k1, input int k2, input int k3);
        pack = {7'(k3), 7'(k2), 7'(k1), 7'(k0)};
    endfunction

    task automatic set_keys(input int a, input int b, input int c, input int d, input int e);
        iKEYS = '0;
        if (a >= 0) iKEYS[a] = 1'b1;
        if (b >= 0) iKEYS[b] = 1'b1;
        if (c >= 0) iKEYS[c] = 1'b1;
        if (d >= 0) iKEYS[d] = 1'b1;
        if (e >= 0) iKEYS[e] = 1'b1;
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // runs until the next oSWEEP_DONE (bounded), tallying pulses; sweep_len counts edges
    task automatic run_sweep();
        sweep_len  = 0;
        drop_cnt   = 0;
        first_trig = -1;
        for (int v = 0; v < 4; v++) trig_cnt[v] = 0;
        do begin
            step();
            sweep_len++;
            for (int v = 0; v < 4; v++) if (oVOICE_TRIG[v]) trig_cnt[v]++;
            if (oDROP) drop_cnt++;
            if ((|oVOICE_TRIG) && first_trig < 0) first_trig = sweep_len;
        end while (!oSWEEP_DONE && sweep_len < 200);
    endtask

    task automatic count_done(input int n);
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (oSWEEP_DONE) done_cnt++;
        end
    endtask

    initial begin
        iRST = 1'b1; iSCAN_EN = 1'b0; iCLR = 1'b0; iKEYS = '0;
        step(); step();
        chk("rst_key",  32'(oVOICE_KEY), 0);
        chk("rst_gate", 32'(oVOICE_GATE), 0);
        chk("rst_trig", 32'(oVOICE_TRIG), 0);
        chk("rst_misc", {29'd0, oDROP, oSWEEP_DONE, oANY_GATE}, 0);
        iRST = 1'b0;

        // idle without scan enable: no sweeps
        count_done(20);
        chk("idle_no_done", done_cnt, 0);

        // first sweep timing and sweep period
        iSCAN_EN = 1'b1;
        run_sweep();
        chk("first_done_lat", sweep_len, 90);
        run_sweep();
        chk("sweep_period", sweep_len, 90);
        chk("empty_trig", trig_cnt[0] + trig_cnt[1] + trig_cnt[2] + trig_cnt[3], 0);

        // single key 40
        set_keys(40, -1, -1, -1, -1);
        run_sweep();
        chk("k40_trig0", trig_cnt[0], 1);
        chk("k40_trig_other", trig_cnt[1] + trig_cnt[2] + trig_cnt[3], 0);
        chk("k40_trig_time", first_trig, 43);
        chk("k40_gate", 32'(oVOICE_GATE), 32'h1);
        chk("k40_key0", 32'(oVOICE_KEY[6:0]), 40);
        chk("k40_any", 32'(oANY_GATE), 1);
        run_sweep();
        chk("k40_held_notrig", trig_cnt[0] + trig_cnt[1] + trig_cnt[2] + trig_cnt[3], 0);
        set_keys(-1, -1, -1, -1, -1);
        run_sweep();
        chk("k40_rel_gate", 32'(oVOICE_GATE), 0);
        chk("k40_rel_keyheld", 32'(oVOICE_KEY[6:0]), 40);
        chk("k40_rel_any", 32'(oANY_GATE), 0);

        // fill all four voices
        set_keys(10, 20, 30, 40, -1);
        run_sweep();
        for (int v = 0; v < 4; v++) chk("fill_trig", trig_cnt[v], 1);
        chk("fill_first_trig", first_trig, 13);
        chk("fill_keys", 32'(oVOICE_KEY), 32'(pack(10, 20, 30, 40)));
        chk("fill_gate", 32'(oVOICE_GATE), 32'hF);
        chk("fill_any", 32'(oANY_GATE), 1);

        // overflow with key 50
        set_keys(10, 20, 30, 40, 50);
        run_sweep();
`ifdef VOICE_STEAL_EN
        chk("steal_drop", drop_cnt, 0);
        chk("steal_trig0", trig_cnt[0], 1);
        chk("steal_trig_other", trig_cnt[1] + trig_cnt[2] + trig_cnt[3], 0);
        chk("steal_keys", 32'(oVOICE_KEY), 32'(pack(50, 20, 30, 40)));
        chk("steal_gate", 32'(oVOICE_GATE), 32'hF);
`else
        chk("ovf_drop1", drop_cnt, 1);
        chk("ovf_notrig1", trig_cnt[0] + trig_cnt[1] + trig_cnt[2] + trig_cnt[3], 0);
        run_sweep();
        chk("ovf_drop2", drop_cnt, 1);
        chk("ovf_keys", 32'(oVOICE_KEY), 32'(pack(10, 20, 30, 40)));
        set_keys(10, 30, 40, 50, -1);
        run_sweep();
        chk("ovf_rel_drop", drop_cnt, 0);
        chk("ovf_rel_trig1", trig_cnt[1], 1);
        chk("ovf_rel_trig_other", trig_cnt[0] + trig_cnt[2] + trig_cnt[3], 0);
        chk("ovf_rel_keys", 32'(oVOICE_KEY), 32'(pack(10, 50, 30, 40)));
        chk("ovf_rel_gate", 32'(oVOICE_GATE), 32'hF);
`endif

        // three held keys, then clear mid-sweep
        set_keys(10, 30, 50, -1, -1);
        run_sweep();
`ifndef VOICE_STEAL_EN
        chk("pre_clr_gate", 32'(oVOICE_GATE), 32'h7);
`endif
        repeat (30) step();
        iCLR = 1'b1;
        step();
        iCLR = 1'b0;
        chk("clr_gate", 32'(oVOICE_GATE), 0);
        chk("clr_any", 32'(oANY_GATE), 0);
        chk("clr_trig", 32'(oVOICE_TRIG), 0);
        chk("clr_done", 32'(oSWEEP_DONE), 0);
        run_sweep();
        chk("clr_restart_len", sweep_len, 89);
        chk("clr_rebind_keys", 32'(oVOICE_KEY), 32'(pack(10, 30, 50, 40)));
        chk("clr_rebind_gate", 32'(oVOICE_GATE), 32'h7);
        chk("clr_rebind_trig", trig_cnt[0] * 100 + trig_cnt[1] * 10 + trig_cnt[2], 111);

        // scan enable dropped mid-sweep: sweep completes, then gates freeze in IDLE
        repeat (20) step();
        iSCAN_EN = 1'b0;
        run_sweep();
        chk("scan_off_finish", sweep_len, 70);
        set_keys(-1, -1, -1, -1, -1);
        count_done(120);
        chk("scan_off_no_done", done_cnt, 0);
        chk("scan_off_frozen", 32'(oVOICE_GATE), 32'h7);

        // reset mid-sweep
        iSCAN_EN = 1'b1;
        repeat (40) step();
        iRST = 1'b1;
        step();
        chk("mid_rst_gate", 32'(oVOICE_GATE), 0);
        chk("mid_rst_key", 32'(oVOICE_KEY), 0);
        chk("mid_rst_pulses", {29'd0, oDROP, oSWEEP_DONE, oANY_GATE}, 0);
        iRST = 1'b0;
        iSCAN_EN = 1'b0;
        count_done(100);
        chk("mid_rst_idle", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
